// File: rtl/datamem_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : datamem_rmw
//  Description : Word-organised data memory with req/ready handshake,
//                registered reads, half-word reads (zero-extended) and
//                half-word writes performed as a 2-cycle read-modify-write.
//                An optional sequencer clears every location after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module datamem_rmw #(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ready,
  input  logic          memWrite,
  input  logic [1:0]    sel,
  input  logic [AW-1:0] dataAddress,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] dataOut,
  output logic          rdValid,
  output logic          busy,
  output logic          err
);

  localparam int HW    = DW / 2;
  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_RMW  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] rmw_addr;
  logic [HW-1:0] rmw_half;
  logic          rmw_hi;
  logic [DW-1:0] hold;
  logic [DW-1:0] core [DEPTH];

  logic          accept;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rd_field;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign ready  = (state == S_IDLE);
  assign busy   = (state == S_INIT);
  assign accept = req & ready;

  // Asynchronous array read feeding both the read path and the RMW snapshot.
  assign rd_word = core[dataAddress];

  // Select the requested field; halves are zero-extended to full width.
  always_comb begin
    rd_field = rd_word;
    case (sel)
      2'd1:    rd_field = {{HW{1'b0}}, rd_word[HW-1:0]};
      2'd2:    rd_field = {{HW{1'b0}}, rd_word[DW-1:HW]};
      default: rd_field = rd_word;
    endcase
  end

  // Single write port shared by clear, full-word write and RMW merge; reset blocks all writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = dataAddress;
    mem_wdata = data;
    if (!reset) begin
      case (state)
        S_INIT: begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt;
          mem_wdata = '0;
        end
        S_IDLE: begin
          mem_we = accept & memWrite & (sel == 2'd0);
        end
        S_RMW: begin
          mem_we    = 1'b1;
          mem_waddr = rmw_addr;
          mem_wdata = rmw_hi ? {rmw_half, hold[HW-1:0]} : {hold[DW-1:HW], rmw_half};
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  // Storage array, whole-word writes only.
  always_ff @(posedge clk) begin
    if (mem_we) core[mem_waddr] <= mem_wdata;
  end

  // Capture half-write context and the current word for the merge cycle.
  always_ff @(posedge clk) begin
    if (accept && memWrite && (sel == 2'd1 || sel == 2'd2)) begin
      rmw_addr <= dataAddress;
      rmw_half <= data[HW-1:0];
      rmw_hi   <= sel[1];
      hold     <= rd_word;
    end
  end

  // Control sequencing, read result register and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;
      clr_cnt <= '0;
      dataOut <= '0;
      rdValid <= 1'b0;
      err     <= 1'b0;
    end else begin
      rdValid <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            if (sel == 2'd3) begin
              err <= 1'b1;
            end else if (!memWrite) begin
              dataOut <= rd_field;
              rdValid <= 1'b1;
            end else if (sel != 2'd0) begin
              state <= S_RMW;
            end
          end
        end
        S_RMW:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datamem_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datamem_rmw
//  Description : Scoreboard bench for datamem_rmw (cleared and uncleared builds)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datamem_rmw;

  typedef struct packed {
    logic       is_err;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       ready;
  logic       memWrite = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] dataAddress = 8'd0;
  logic [7:0] data = 8'd0;
  logic [7:0] dataOut;
  logic       rdValid;
  logic       busy;
  logic       err;

  logic       reset2 = 1'b1;
  logic       req2 = 1'b0;
  logic       ready2;
  logic       memWrite2 = 1'b0;
  logic [1:0] sel2 = 2'd0;
  logic [7:0] dataAddress2 = 8'd0;
  logic [7:0] data2 = 8'd0;
  logic [7:0] dataOut2;
  logic       rdValid2;
  logic       busy2;
  logic       err2;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  datamem_rmw #(.DW(8), .AW(8), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready), .memWrite(memWrite),
    .sel(sel), .dataAddress(dataAddress), .data(data), .dataOut(dataOut),
    .rdValid(rdValid), .busy(busy), .err(err)
  );

  datamem_rmw #(.DW(8), .AW(8), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset(reset2), .req(req2), .ready(ready2), .memWrite(memWrite2),
    .sel(sel2), .dataAddress(dataAddress2), .data(data2), .dataOut(dataOut2),
    .rdValid(rdValid2), .busy(busy2), .err(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pop one expectation for every rdValid or err pulse.
  always @(negedge clk) begin
    if (rdValid === 1'b1 || err === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {30'd0, rdValid, err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_err) begin
          chk("err_pulse", {31'd0, err}, 32'd1);
          chk("err_no_rdvalid", {31'd0, rdValid}, 32'd0);
          chk("err_dataout_held", {24'd0, dataOut}, {24'd0, last_rd});
        end else begin
          chk("rd_data", {24'd0, dataOut}, {24'd0, e.d});
          chk("rd_no_err", {31'd0, err}, 32'd0);
          last_rd = e.d;
        end
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, record the expected response.
  task automatic access(input logic we, input logic [1:0] s, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] expd);
    int n;
    exp_t e;
    req = 1'b1; memWrite = we; sel = s; dataAddress = a; data = d;
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      if (s == 2'd3) begin
        e.is_err = 1'b1; e.d = 8'h00; q.push_back(e);
      end else if (!we) begin
        e.is_err = 1'b0; e.d = expd; q.push_back(e);
      end
      #1;
    end
    req = 1'b0;
  endtask

  // Count cycles from reset release until ready, checking busy throughout.
  task automatic count_init(input string name);
    int n;
    int bad_busy;
    n = 0; bad_busy = 0;
    while (ready !== 1'b1 && n < 1000) begin
      if (busy !== 1'b1) bad_busy++;
      @(posedge clk); #1; n++;
    end
    chk(name, n, 256);
    chk("busy_during_init", bad_busy, 0);
    chk("busy_after_init", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1; req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    // 1: reset values and clear duration
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pulse_reset();
    chk("rst_dataout", {24'd0, dataOut}, 32'd0);
    chk("rst_rdvalid", {31'd0, rdValid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    count_init("init_cycles");
    access(1'b0, 2'd0, 8'h7F, 8'h00, 8'h00);

    // 2: full write then back-to-back full/low/high reads
    access(1'b1, 2'd0, 8'h10, 8'hA5, 8'h00);
    access(1'b0, 2'd0, 8'h10, 8'h00, 8'hA5);
    access(1'b0, 2'd1, 8'h10, 8'h00, 8'h05);
    access(1'b0, 2'd2, 8'h10, 8'h00, 8'h0A);
    chk("b2b_rdvalid", {31'd0, rdValid}, 32'd1);

    // 3: high-half then low-half read-modify-write
    access(1'b1, 2'd2, 8'h10, 8'h3C, 8'h00);
    chk("rmw_hi_ready_low", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("rmw_hi_ready_back", {31'd0, ready}, 32'd1);
    access(1'b0, 2'd0, 8'h10, 8'h00, 8'hC5);
    access(1'b1, 2'd1, 8'h10, 8'h07, 8'h00);
    chk("rmw_lo_ready_low", {31'd0, ready}, 32'd0);
    access(1'b0, 2'd0, 8'h10, 8'h00, 8'hC7);

    // 4: illegal select on read and write
    access(1'b0, 2'd3, 8'h10, 8'h00, 8'h00);
    access(1'b1, 2'd3, 8'h10, 8'hFF, 8'h00);
    access(1'b0, 2'd0, 8'h10, 8'h00, 8'hC7);
    repeat (3) @(posedge clk);

    // 5: reset during RMW, then reset part-way through clear
    access(1'b1, 2'd1, 8'h10, 8'h09, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    count_init("init_after_rmw_reset");
    access(1'b0, 2'd0, 8'h10, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    pulse_reset();
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    count_init("init_after_midclear_reset");

    // 6: extreme addresses
    access(1'b1, 2'd0, 8'hFF, 8'h5A, 8'h00);
    access(1'b1, 2'd0, 8'h00, 8'h11, 8'h00);
    access(1'b0, 2'd0, 8'hFF, 8'h00, 8'h5A);
    access(1'b0, 2'd0, 8'h00, 8'h00, 8'h11);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);

    // 6b: build without clear sequencer
    @(posedge clk); #1 reset2 = 1'b0;
    @(posedge clk); #1 reset2 = 1'b1;
    @(posedge clk); #1 reset2 = 1'b0;
    chk("noclr_ready_after_reset", {31'd0, ready2}, 32'd1);
    chk("noclr_busy", {31'd0, busy2}, 32'd0);
    req2 = 1'b1; memWrite2 = 1'b1; sel2 = 2'd0; dataAddress2 = 8'hFF; data2 = 8'h5A;
    @(posedge clk); #1 dataAddress2 = 8'h00; data2 = 8'h11;
    @(posedge clk); #1 memWrite2 = 1'b0; dataAddress2 = 8'hFF;
    @(posedge clk); #1;
    chk("noclr_rd_ff", {24'd0, dataOut2}, 32'h5A);
    chk("noclr_rdvalid", {31'd0, rdValid2}, 32'd1);
    dataAddress2 = 8'h00;
    @(posedge clk); #1;
    chk("noclr_rd_00", {24'd0, dataOut2}, 32'h11);
    req2 = 1'b0;
    @(posedge clk); #1;
    chk("noclr_rdvalid_drop", {31'd0, rdValid2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
